spi_slave_rx: RTL and testbench

SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

---
 rtl/spi_slave_rx.sv | 147 ++++++++++++++
 tb/tb_spi_slave_rx.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave byte transceiver: synchronizes the SPI pins into clk,
// deserializes mosi into bytes and serializes controller bytes onto miso.
//
// state  | meaning
// IDLE   | deselected; sclk ignored, miso low and not driven
// ACTIVE | selected; bits shift in on sclk rise, out on sclk fall
module spi_slave_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    output logic       spi_tsx_start,
    output logic       spi_tsx_end,
    output logic [7:0] spi_c_data_in,
    output logic       spi_c_data_stb,
    input  logic [7:0] spi_c_data_out
);

    localparam logic [2:0] SETTLE_CYCLES = 3'(SYNC_STAGES + 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sclk_pipe;
    logic [SYNC_STAGES-1:0] cs_pipe;
    logic [SYNC_STAGES-1:0] mosi_pipe;
    logic                   sclk_d;
    logic                   cs_d;
    logic                   sclk_s;
    logic                   cs_s;
    logic                   mosi_s;
    logic                   sclk_rise;
    logic                   sclk_fall;
    logic                   cs_rise;
    logic                   cs_fall;
    logic [2:0]             settle_cnt;
    logic                   settled;
    logic                   cs_armed;
    logic [2:0]             bit_cnt;
    logic [7:0]             rx_shift;
    logic [7:0]             tx_shift;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sclk_pipe <= '0;
            cs_pipe   <= '1;
            mosi_pipe <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sclk_pipe <= {sclk_pipe[SYNC_STAGES-2:0], sclk};
            cs_pipe   <= {cs_pipe[SYNC_STAGES-2:0], cs_n};
            mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
        end
    end

    assign sclk_s    = sclk_pipe[SYNC_STAGES-1];
    assign cs_s      = cs_pipe[SYNC_STAGES-1];
    assign mosi_s    = mosi_pipe[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_rise   = cs_s & ~cs_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign settled   = (settle_cnt == 3'd0);

    // After reset the pipes flush real pin values; a select that was already low
    // must be seen high once before a falling edge may open a transaction.
    always_ff @(posedge clk) begin
        if (!rst) begin
            settle_cnt <= SETTLE_CYCLES;
            cs_armed   <= 1'b0;
        end else if (!settled) begin
            settle_cnt <= settle_cnt - 3'd1;
        end else if (cs_s) begin
            cs_armed <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            bit_cnt        <= 3'd0;
            rx_shift       <= 8'h00;
            tx_shift       <= 8'h00;
            miso_oe        <= 1'b0;
            spi_tsx_start  <= 1'b0;
            spi_tsx_end    <= 1'b0;
            spi_c_data_stb <= 1'b0;
            spi_c_data_in  <= 8'h00;
        end else begin
            spi_tsx_start  <= 1'b0;
            spi_tsx_end    <= 1'b0;
            spi_c_data_stb <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_fall && cs_armed) begin
                        state         <= ACTIVE;
                        spi_tsx_start <= 1'b1;
                        bit_cnt       <= 3'd0;
                        tx_shift      <= spi_c_data_out;
                        miso_oe       <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (sclk_rise) begin
                        rx_shift <= {rx_shift[6:0], mosi_s};
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            spi_c_data_in  <= {rx_shift[6:0], mosi_s};
                            spi_c_data_stb <= 1'b1;
                        end
                    end else if (sclk_fall) begin
                        if (bit_cnt == 3'd0) begin
                            tx_shift <= spi_c_data_out;
                        end else begin
                            tx_shift <= {tx_shift[6:0], 1'b0};
                        end
                    end
                    // Deselect overrides the shift/count updates but not a byte
                    // completing in the same cycle.
                    if (cs_rise) begin
                        state       <= IDLE;
                        spi_tsx_end <= 1'b1;
                        miso_oe     <= 1'b0;
                        bit_cnt     <= 3'd0;
                        tx_shift    <= 8'h00;
                        rx_shift    <= 8'h00;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign miso = tx_shift[7];

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: vector table, hand-written corner sequences and a
// randomized transaction loop checked against a byte/bit-level model.
module tb_spi_slave_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk;
    logic       cs_n;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic       spi_tsx_start;
    logic       spi_tsx_end;
    logic [7:0] spi_c_data_in;
    logic       spi_c_data_stb;
    logic [7:0] spi_c_data_out;

    spi_slave_rx #(.SYNC_STAGES(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .sclk          (sclk),
        .cs_n          (cs_n),
        .mosi          (mosi),
        .miso          (miso),
        .miso_oe       (miso_oe),
        .spi_tsx_start (spi_tsx_start),
        .spi_tsx_end   (spi_tsx_end),
        .spi_c_data_in (spi_c_data_in),
        .spi_c_data_stb(spi_c_data_stb),
        .spi_c_data_out(spi_c_data_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         nbits;
        logic [31:0] mosi_v;
        logic [7:0]  tx0;
        logic [7:0]  tx1;
        int          exp_stb;
        logic [7:0]  exp_last;
        logic [31:0] exp_miso;
    } vec_t;

    int         n_cmp = 0;
    int         n_err = 0;
    int         n_start = 0, n_end = 0, n_stb = 0, cyc = 0, viol = 0;
    int         last_stb_cyc = -1, last_end_cyc = -2;
    logic       prev_start = 1'b0, prev_end = 1'b0, prev_stb = 1'b0;
    logic [7:0] rx_q[$];
    logic [7:0] tx_bytes[16];
    int         tsx_gen = 0;
    logic       mbits[64];
    logic       miso_got[64];
    logic       oe_all;
    logic [7:0] last_byte;
    int         s_start, s_end, s_stb, s_rx;
    vec_t       vecs[6];
    vec_t       cv;

    // Pulse monitor: counts pulses, records strobed bytes and width violations.
    always @(negedge clk) begin
        cyc++;
        if (spi_tsx_start === 1'b1) begin
            n_start++;
            if (prev_start) viol++;
        end
        if (spi_tsx_end === 1'b1) begin
            n_end++;
            last_end_cyc = cyc;
            if (prev_end) viol++;
        end
        if (spi_c_data_stb === 1'b1) begin
            n_stb++;
            last_stb_cyc = cyc;
            rx_q.push_back(spi_c_data_in);
            if (prev_stb) viol++;
        end
        prev_start = (spi_tsx_start === 1'b1);
        prev_end   = (spi_tsx_end === 1'b1);
        prev_stb   = (spi_c_data_stb === 1'b1);
    end

    // Controller model: presents tx_bytes[0] at transaction start, next byte after each strobe.
    initial begin : controller
        int seen_gen;
        int tx_idx;
        seen_gen = 0;
        tx_idx = 0;
        spi_c_data_out = 8'h00;
        forever begin
            @(negedge clk);
            if (tsx_gen != seen_gen) begin
                seen_gen = tsx_gen;
                tx_idx = 0;
                spi_c_data_out = tx_bytes[0];
            end else if (spi_c_data_stb === 1'b1 && tx_idx < 15) begin
                tx_idx++;
                spi_c_data_out = tx_bytes[tx_idx];
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic snap();
        s_start = n_start;
        s_end   = n_end;
        s_stb   = n_stb;
        s_rx    = rx_q.size();
    endtask

    task automatic bit_cycle(input logic m, input int idx);
        mosi = m;
        #50;
        sclk = 1'b1;
        miso_got[idx] = miso;
        oe_all = oe_all & miso_oe;
        #50;
        sclk = 1'b0;
    endtask

    task automatic new_tsx();
        tsx_gen++;
        #20;
    endtask

    task automatic xfer(input int nbits);
        new_tsx();
        oe_all = 1'b1;
        cs_n = 1'b0;
        #100;
        for (int i = 0; i < nbits; i++) bit_cycle(mbits[i], i);
        #100;
        cs_n = 1'b1;
        #200;
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] mask;
        logic [7:0]  b;
        logic [7:0]  eb;
        int          nb;
        int          bad;
        int          exp_n;
        logic        seen_miso;
        logic        seen_oe;

        vecs[0] = '{8,  32'h0100_0000, 8'h00, 8'h00, 1, 8'h01, 32'h0000_0000};
        vecs[1] = '{16, 32'h0203_0000, 8'hA5, 8'h3C, 2, 8'h03, 32'hA53C_0000};
        vecs[2] = '{5,  32'hB000_0000, 8'h5A, 8'h00, 0, 8'h03, 32'h5A00_0000};
        vecs[3] = '{24, 32'hDEAD_BE00, 8'hF0, 8'h0F, 3, 8'hBE, 32'hF00F_0F00};
        vecs[4] = '{0,  32'h0000_0000, 8'hFF, 8'hFF, 0, 8'hBE, 32'h0000_0000};
        vecs[5] = '{9,  32'hC080_0000, 8'h81, 8'h7E, 1, 8'hC0, 32'h8100_0000};

        rst = 1'b0;
        sclk = 1'b0;
        cs_n = 1'b1;
        mosi = 1'b0;
        for (int k = 0; k < 16; k++) tx_bytes[k] = 8'h00;
        #58;
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_miso_oe", 32'(miso_oe), 32'd0);
        check("rst_start", 32'(spi_tsx_start), 32'd0);
        check("rst_end", 32'(spi_tsx_end), 32'd0);
        check("rst_stb", 32'(spi_c_data_stb), 32'd0);
        check("rst_data_in", 32'(spi_c_data_in), 32'd0);
        rst = 1'b1;
        #100;
        check("release_no_start", 32'(n_start), 32'd0);
        check("release_no_end", 32'(n_end), 32'd0);
        last_byte = 8'h00;

        for (int v = 0; v < 6; v++) begin
            cv = vecs[v];
            tx_bytes[0] = cv.tx0;
            for (int k = 1; k < 16; k++) tx_bytes[k] = cv.tx1;
            for (int i = 0; i < 64; i++) mbits[i] = (i < 32) ? cv.mosi_v[31-i] : 1'b0;
            snap();
            xfer(cv.nbits);
            check("vec_start", 32'(n_start - s_start), 32'd1);
            check("vec_end", 32'(n_end - s_end), 32'd1);
            check("vec_stb_count", 32'(n_stb - s_stb), 32'(cv.exp_stb));
            check("vec_data_in", 32'(spi_c_data_in), 32'(cv.exp_last));
            check("vec_idle_oe", 32'(miso_oe), 32'd0);
            check("vec_idle_miso", 32'(miso), 32'd0);
            if (cv.nbits > 0) begin
                got = '0;
                for (int i = 0; i < cv.nbits; i++) got[31-i] = miso_got[i];
                mask = ~(32'hFFFF_FFFF >> cv.nbits);
                check("vec_miso_bits", got & mask, cv.exp_miso & mask);
                check("vec_oe_active", 32'(oe_all), 32'd1);
            end
            last_byte = cv.exp_last;
        end

        // sclk activity while deselected
        snap();
        seen_miso = 1'b0;
        seen_oe = 1'b0;
        for (int i = 0; i < 10; i++) begin
            mosi = 1'($urandom_range(0, 1));
            sclk = 1'b1;
            #50;
            seen_miso = seen_miso | miso;
            seen_oe = seen_oe | miso_oe;
            sclk = 1'b0;
            #50;
        end
        check("idle_sclk_stb", 32'(n_stb - s_stb), 32'd0);
        check("idle_sclk_start", 32'(n_start - s_start), 32'd0);
        check("idle_sclk_miso", 32'(seen_miso), 32'd0);
        check("idle_sclk_oe", 32'(seen_oe), 32'd0);
        check("idle_sclk_data_in", 32'(spi_c_data_in), 32'(last_byte));

        // deselect on the same instant as the 8th sclk rise
        snap();
        b = 8'h97;
        tx_bytes[0] = 8'h00;
        new_tsx();
        oe_all = 1'b1;
        cs_n = 1'b0;
        #100;
        for (int j = 0; j < 7; j++) bit_cycle(b[7-j], j);
        mosi = b[0];
        #50;
        sclk = 1'b1;
        cs_n = 1'b1;
        #50;
        sclk = 1'b0;
        #200;
        check("cs_rise_8th_stb", 32'(n_stb - s_stb), 32'd1);
        check("cs_rise_8th_end", 32'(n_end - s_end), 32'd1);
        check("cs_rise_8th_same_cycle", 32'(last_end_cyc), 32'(last_stb_cyc));
        check("cs_rise_8th_data", 32'(spi_c_data_in), 32'h97);
        last_byte = 8'h97;

        // select on the same instant as an sclk rise: that edge is ignored
        snap();
        b = 8'h5A;
        new_tsx();
        mosi = 1'b1;
        cs_n = 1'b0;
        sclk = 1'b1;
        #50;
        sclk = 1'b0;
        for (int j = 0; j < 8; j++) bit_cycle(b[7-j], j);
        #100;
        cs_n = 1'b1;
        #200;
        check("cs_fall_sclk_start", 32'(n_start - s_start), 32'd1);
        check("cs_fall_sclk_stb", 32'(n_stb - s_stb), 32'd1);
        check("cs_fall_sclk_data", 32'(spi_c_data_in), 32'h5A);
        check("cs_fall_sclk_end", 32'(n_end - s_end), 32'd1);

        // reset in mid-transaction, released with cs_n still low
        snap();
        tx_bytes[0] = 8'hC3;
        new_tsx();
        cs_n = 1'b0;
        #100;
        for (int j = 0; j < 4; j++) bit_cycle(1'b1, j);
        rst = 1'b0;
        #50;
        check("midrst_miso", 32'(miso), 32'd0);
        check("midrst_oe", 32'(miso_oe), 32'd0);
        check("midrst_data_in", 32'(spi_c_data_in), 32'd0);
        check("midrst_pulses", 32'({spi_tsx_start, spi_tsx_end, spi_c_data_stb}), 32'd0);
        rst = 1'b1;
        #100;
        for (int j = 0; j < 8; j++) bit_cycle(1'b1, j);
        #100;
        check("postrst_no_start", 32'(n_start - s_start), 32'd1);
        check("postrst_no_stb", 32'(n_stb - s_stb), 32'd0);
        cs_n = 1'b1;
        #200;
        check("postrst_no_end", 32'(n_end - s_end), 32'd0);
        last_byte = 8'h00;
        for (int i = 0; i < 8; i++) mbits[i] = 1'b1;
        tx_bytes[0] = 8'h00;
        snap();
        xfer(8);
        check("postrst_ff_start", 32'(n_start - s_start), 32'd1);
        check("postrst_ff_stb", 32'(n_stb - s_stb), 32'd1);
        check("postrst_ff_data", 32'(spi_c_data_in), 32'hFF);
        last_byte = 8'hFF;

        // randomized transactions against the byte/bit model
        for (int t = 0; t < 20; t++) begin
            nb = $urandom_range(0, 40);
            for (int i = 0; i < 64; i++) mbits[i] = 1'($urandom_range(0, 1));
            for (int k = 0; k < 16; k++) tx_bytes[k] = 8'($urandom);
            snap();
            xfer(nb);
            exp_n = nb / 8;
            check("rnd_start", 32'(n_start - s_start), 32'd1);
            check("rnd_end", 32'(n_end - s_end), 32'd1);
            check("rnd_stb_count", 32'(n_stb - s_stb), 32'(exp_n));
            for (int k = 0; k < exp_n; k++) begin
                eb = 8'h00;
                for (int j = 0; j < 8; j++) eb = {eb[6:0], mbits[8*k+j]};
                if (s_rx + k < rx_q.size()) check("rnd_rx_byte", 32'(rx_q[s_rx+k]), 32'(eb));
                last_byte = eb;
            end
            check("rnd_data_in", 32'(spi_c_data_in), 32'(last_byte));
            bad = 0;
            for (int i = 0; i < nb; i++) begin
                eb = tx_bytes[i/8];
                if (miso_got[i] !== eb[7-(i%8)]) bad++;
            end
            check("rnd_miso_bits", 32'(bad), 32'd0);
        end

        check("pulse_width", 32'(viol), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
